// File: rtl/level_ctrl_if.sv
// Control/status bundle between the game controller and its player-input logic.
// The master drives the player pulses and level threshold; the slave reports game state.
interface level_ctrl_if;
   logic        start;
   logic        hit;
   logic        miss;
   logic [31:0] max_points;
   logic [3:0]  level;
   logic [31:0] points;
   logic [1:0]  lives;
   logic        level_pulse;
   logic        playing;
   logic        game_won;
   logic        game_over;

   modport master (
      output start, hit, miss, max_points,
      input  level, points, lives, level_pulse, playing, game_won, game_over
   );

   modport slave (
      input  start, hit, miss, max_points,
      output level, points, lives, level_pulse, playing, game_won, game_over
   );
endinterface

// File: rtl/level_ctrl.sv
// Game level controller: tracks level, cumulative points and lives, and steps
// through IDLE / SETTLE / PLAY / WIN / LOSE in response to start, hit and miss pulses.
module level_ctrl #(
   parameter int MAX_LEVEL     = 8,
   parameter int LIVES         = 3,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   level_ctrl_if.slave  bus
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETTLE = 3'd1,
      ST_PLAY   = 3'd2,
      ST_WIN    = 3'd3,
      ST_LOSE   = 3'd4
   } state_t;

   localparam logic [3:0] MAX_LEVEL_L = 4'(MAX_LEVEL);
   localparam logic [1:0] LIVES_INIT  = 2'(LIVES);
   localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

   state_t      state_r;
   logic [3:0]  settle_cnt_r;
   logic [3:0]  level_r;
   logic [31:0] points_r;
   logic [1:0]  lives_r;
   logic        level_pulse_r;
   logic        playing_r;
   logic        game_won_r;
   logic        game_over_r;

   logic [31:0] points_inc_s;
   logic        goal_s;

   function automatic logic [31:0] sat_inc32(input logic [31:0] value);
      if (value == 32'hFFFF_FFFF) begin
         return value;
      end else begin
         return value + 32'd1;
      end
   endfunction

   // Saturated next score and whether it reaches this level's threshold.
   always_comb begin
      points_inc_s = sat_inc32(points_r);
      goal_s       = (points_inc_s >= bus.max_points);
   end

   // Game FSM with all outputs registered alongside the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= ST_IDLE;
         settle_cnt_r  <= 4'd0;
         level_r       <= 4'd1;
         points_r      <= 32'd0;
         lives_r       <= LIVES_INIT;
         level_pulse_r <= 1'b0;
         playing_r     <= 1'b0;
         game_won_r    <= 1'b0;
         game_over_r   <= 1'b0;
      end else begin
         level_pulse_r <= 1'b0;
         if (bus.start) begin
            state_r      <= ST_SETTLE;
            settle_cnt_r <= SETTLE_INIT;
            level_r      <= 4'd1;
            points_r     <= 32'd0;
            lives_r      <= LIVES_INIT;
            playing_r    <= 1'b0;
            game_won_r   <= 1'b0;
            game_over_r  <= 1'b0;
         end else begin
            case (state_r)
               ST_SETTLE: begin
                  // Downstream table re-registers; player pulses are dropped here.
                  if (settle_cnt_r <= 4'd1) begin
                     settle_cnt_r <= 4'd0;
                     state_r      <= ST_PLAY;
                     playing_r    <= 1'b1;
                  end else begin
                     settle_cnt_r <= settle_cnt_r - 4'd1;
                  end
               end
               ST_PLAY: begin
                  if (bus.miss) begin
                     if (lives_r <= 2'd1) begin
                        lives_r     <= 2'd0;
                        state_r     <= ST_LOSE;
                        playing_r   <= 1'b0;
                        game_over_r <= 1'b1;
                     end else begin
                        lives_r <= lives_r - 2'd1;
                     end
                  end else if (bus.hit) begin
                     points_r <= points_inc_s;
                     if (!goal_s) begin
                        state_r <= ST_PLAY;
                     end else if (level_r >= MAX_LEVEL_L) begin
                        state_r    <= ST_WIN;
                        playing_r  <= 1'b0;
                        game_won_r <= 1'b1;
                     end else begin
                        level_r       <= level_r + 4'd1;
                        level_pulse_r <= 1'b1;
                        state_r       <= ST_SETTLE;
                        settle_cnt_r  <= SETTLE_INIT;
                        playing_r     <= 1'b0;
                     end
                  end else begin
                     state_r <= ST_PLAY;
                  end
               end
               ST_IDLE, ST_WIN, ST_LOSE: begin
                  state_r <= state_r;
               end
               default: begin
                  // Unreachable encoding: fall back to a quiet idle.
                  state_r     <= ST_IDLE;
                  playing_r   <= 1'b0;
                  game_won_r  <= 1'b0;
                  game_over_r <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.level       = level_r;
   assign bus.points      = points_r;
   assign bus.lives       = lives_r;
   assign bus.level_pulse = level_pulse_r;
   assign bus.playing     = playing_r;
   assign bus.game_won    = game_won_r;
   assign bus.game_over   = game_over_r;

endmodule

// File: tb/tb_level_ctrl.sv
// Scoreboard bench for level_ctrl: a reference model predicts every cycle's outputs,
// plus direct checks of the documented game scenarios.
module tb_level_ctrl;

   localparam int M_IDLE   = 0;
   localparam int M_SETTLE = 1;
   localparam int M_PLAY   = 2;
   localparam int M_WIN    = 3;
   localparam int M_LOSE   = 4;

   typedef struct {
      logic [3:0]  level;
      logic [31:0] points;
      logic [1:0]  lives;
      logic        pulse;
      logic        playing;
      logic        won;
      logic        over;
   } snap_t;

   logic clk;
   logic rst_n;
   level_ctrl_if bus();

   int n_checks = 0;
   int n_errors = 0;
   snap_t sb_q[$];

   int m_state;
   int m_level;
   longint m_points;
   int m_lives;
   int m_cnt;
   bit m_pulse;

   function automatic logic [31:0] mp_tbl(input logic [3:0] lvl);
      return 32'(lvl) * 32'd8;
   endfunction

   assign bus.max_points = mp_tbl(bus.level);

   level_ctrl #(.MAX_LEVEL(8), .LIVES(3), .SETTLE_CYCLES(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_state = M_IDLE; m_level = 1; m_points = 0; m_lives = 3; m_cnt = 0; m_pulse = 0;
   endtask

   task automatic model_step(input bit s, input bit h, input bit m);
      longint np;
      m_pulse = 0;
      if (s) begin
         m_state = M_SETTLE; m_cnt = 2; m_level = 1; m_points = 0; m_lives = 3;
      end else if (m_state == M_SETTLE) begin
         m_cnt--;
         if (m_cnt == 0) m_state = M_PLAY;
      end else if (m_state == M_PLAY) begin
         if (m) begin
            m_lives--;
            if (m_lives == 0) m_state = M_LOSE;
         end else if (h) begin
            np = (m_points == 64'h0000_0000_FFFF_FFFF) ? m_points : m_points + 1;
            m_points = np;
            if (np >= longint'(mp_tbl(4'(m_level)))) begin
               if (m_level == 8) m_state = M_WIN;
               else begin
                  m_level++; m_pulse = 1; m_state = M_SETTLE; m_cnt = 2;
               end
            end
         end
      end
   endtask

   function automatic snap_t model_snap();
      snap_t e;
      e.level   = 4'(m_level);
      e.points  = 32'(m_points);
      e.lives   = 2'(m_lives);
      e.pulse   = m_pulse;
      e.playing = (m_state == M_PLAY);
      e.won     = (m_state == M_WIN);
      e.over    = (m_state == M_LOSE);
      return e;
   endfunction

   task automatic compare_snap(input string tag, input snap_t e);
      check_val({tag, ".level"},   32'(bus.level),       32'(e.level));
      check_val({tag, ".points"},  bus.points,           e.points);
      check_val({tag, ".lives"},   32'(bus.lives),       32'(e.lives));
      check_val({tag, ".pulse"},   32'(bus.level_pulse), 32'(e.pulse));
      check_val({tag, ".playing"}, 32'(bus.playing),     32'(e.playing));
      check_val({tag, ".won"},     32'(bus.game_won),    32'(e.won));
      check_val({tag, ".over"},    32'(bus.game_over),   32'(e.over));
   endtask

   // Drive one cycle of pulses, queue the prediction, then compare after the edge.
   task automatic step(input string tag, input bit s, input bit h, input bit m);
      snap_t e;
      bus.start = s; bus.hit = h; bus.miss = m;
      model_step(s, h, m);
      sb_q.push_back(model_snap());
      @(posedge clk); #1;
      bus.start = 1'b0; bus.hit = 1'b0; bus.miss = 1'b0;
      check_val({tag, ".sb_depth"}, 32'(sb_q.size()), 32'd1);
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         compare_snap(tag, e);
      end
   endtask

   task automatic play_step(input string tag);
      if (m_state == M_PLAY) step(tag, 1'b0, 1'b1, 1'b0);
      else step(tag, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0;
      bus.start = 1'b0; bus.hit = 1'b0; bus.miss = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_snap("reset", model_snap());

      // Release reset with a coincident hit; IDLE must ignore it.
      rst_n = 1'b1;
      step("rel_hit", 1'b0, 1'b1, 1'b0);
      check_val("rel_hit_points", bus.points, 32'd0);

      // Start, settle two cycles, then eight hits advance level 1 -> 2.
      step("start1", 1'b1, 1'b0, 1'b0);
      step("settle1a", 1'b0, 1'b0, 1'b0);
      check_val("settle_playing0", 32'(bus.playing), 32'd0);
      step("settle1b", 1'b0, 1'b0, 1'b0);
      check_val("settle_playing1", 32'(bus.playing), 32'd1);
      for (int i = 0; i < 8; i++) step("hits_l1", 1'b0, 1'b1, 1'b0);
      check_val("adv_level2", 32'(bus.level), 32'd2);
      check_val("adv_points8", bus.points, 32'd8);
      check_val("adv_pulse", 32'(bus.level_pulse), 32'd1);
      check_val("adv_playing", 32'(bus.playing), 32'd0);

      // A hit during SETTLE is dropped.
      step("settle_hit", 1'b0, 1'b1, 1'b0);
      check_val("settle_hit_points", bus.points, 32'd8);
      check_val("pulse_one_cycle", 32'(bus.level_pulse), 32'd0);
      step("settle2", 1'b0, 1'b0, 1'b0);
      check_val("play_again", 32'(bus.playing), 32'd1);
      for (int i = 0; i < 8; i++) step("hits_l2", 1'b0, 1'b1, 1'b0);
      check_val("adv_level3", 32'(bus.level), 32'd3);

      // Run the table to the end: 64 points total wins at level 8.
      for (int i = 0; i < 400 && m_state != M_WIN; i++) play_step("run_win");
      check_val("win_level", 32'(bus.level), 32'd8);
      check_val("win_points", bus.points, 32'd64);
      check_val("win_flag", 32'(bus.game_won), 32'd1);
      check_val("win_no_pulse", 32'(bus.level_pulse), 32'd0);
      step("win_hit", 1'b0, 1'b1, 1'b0);
      check_val("win_hold_points", bus.points, 32'd64);

      // Three misses lose the game; later hits change nothing.
      step("start2", 1'b1, 1'b0, 1'b0);
      repeat (2) step("settle3", 1'b0, 1'b0, 1'b0);
      step("miss1", 1'b0, 1'b0, 1'b1);
      check_val("lives2", 32'(bus.lives), 32'd2);
      step("miss2", 1'b0, 1'b0, 1'b1);
      check_val("lives1", 32'(bus.lives), 32'd1);
      step("miss3", 1'b0, 1'b0, 1'b1);
      check_val("lives0", 32'(bus.lives), 32'd0);
      check_val("over_flag", 32'(bus.game_over), 32'd1);
      step("lose_hit", 1'b0, 1'b1, 1'b0);
      check_val("lose_points", bus.points, 32'd0);

      // Simultaneous hit and miss: miss wins, hit discarded.
      step("start3", 1'b1, 1'b0, 1'b0);
      repeat (2) step("settle4", 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step("hits5", 1'b0, 1'b1, 1'b0);
      step("hit_miss", 1'b0, 1'b1, 1'b1);
      check_val("hm_points", bus.points, 32'd5);
      check_val("hm_lives", 32'(bus.lives), 32'd2);

      // Start coincident with a hit restarts the game.
      step("start_hit", 1'b1, 1'b1, 1'b0);
      check_val("sh_points", bus.points, 32'd0);
      check_val("sh_lives", 32'(bus.lives), 32'd3);

      // Climb to level 4 with 27 points, then reset asynchronously mid-cycle.
      for (int i = 0; i < 200 && !(m_level == 4 && m_points == 27); i++) play_step("run_l4");
      check_val("pre_rst_level", 32'(bus.level), 32'd4);
      check_val("pre_rst_points", bus.points, 32'd27);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      compare_snap("async_rst", model_snap());
      @(posedge clk); #1;
      rst_n = 1'b1;
      step("start4", 1'b1, 1'b0, 1'b0);
      check_val("post_rst_settle", 32'(bus.playing), 32'd0);
      repeat (2) step("settle5", 1'b0, 1'b0, 1'b0);
      check_val("post_rst_play", 32'(bus.playing), 32'd1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
